// File: rtl/param_bus_arbiter.sv
// Round-robin arbiter sharing one SIZE-bit valid/ready bus among NREQ requesters.
// Optional stall timeout with sticky err flag is enabled by defining ARB_TIMEOUT_EN.
module param_bus_arbiter #(
    parameter int SIZE      = 4,
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] data_in,
    output logic [NREQ-1:0]      grant,
    output logic [SIZE-1:0]      bus_data,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] r_grant, w_grant_next;
    logic [IW-1:0]   r_last, w_last_next;
    logic [3:0]      r_beat_cnt, w_beat_next;
    logic [IW-1:0]   w_sel;
    logic            w_sel_found;
    int              w_scan_idx;
    logic [SIZE-1:0] w_masked [NREQ];
    logic            w_stall_to;

    // Scan starting just after the last winner so the previous owner ranks lowest.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        w_scan_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = (int'(r_last) + k) % NREQ;
            if (!w_sel_found && req[w_scan_idx[IW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel       = w_scan_idx[IW-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign w_masked[gi] = data_in[gi*SIZE +: SIZE] & {SIZE{r_grant[gi]}};
        end
    endgenerate

    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus_data = bus_data | w_masked[i];
        end
    end

    assign bus_valid = |(r_grant & req);
    assign grant     = r_grant;
    assign busy      = (r_state == BUSY);

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_beat_next  = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_sel_found) begin
                    w_state_next = BUSY;
                    w_grant_next = NREQ'(1) << w_sel;
                    w_last_next  = w_sel;
                    w_beat_next  = 4'd0;
                end
            end
            BUSY: begin
                if (!bus_valid) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                end else if (bus_ready) begin
                    if (r_beat_cnt == 4'(MAX_BURST - 1)) begin
                        w_state_next = IDLE;
                        w_grant_next = '0;
                    end else begin
                        w_beat_next = r_beat_cnt + 4'd1;
                    end
                end else if (w_stall_to) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_last     <= IW'(NREQ - 1);
            r_beat_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_last     <= w_last_next;
            r_beat_cnt <= w_beat_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_stall_cnt;
    logic       r_err;
    logic       w_stalling;

    assign w_stalling = (r_state == BUSY) && bus_valid && !bus_ready;
    assign w_stall_to = w_stalling && (r_stall_cnt == 8'(TIMEOUT - 1));
    assign err        = r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            if (w_stalling && !w_stall_to) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end else begin
                r_stall_cnt <= 8'd0;
            end
            r_err <= r_err | w_stall_to;
        end
    end
`else
    assign w_stall_to = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Directed bench for param_bus_arbiter (SIZE=4, NREQ=3, MAX_BURST=2, TIMEOUT=4).
module tb_param_bus_arbiter;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req;
    logic [11:0] data_in;
    logic [2:0]  grant;
    logic [3:0]  bus_data;
    logic        bus_valid;
    logic        bus_ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    param_bus_arbiter #(
        .SIZE(4), .NREQ(3), .MAX_BURST(2), .TIMEOUT(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .data_in(data_in),
        .grant(grant), .bus_data(bus_data), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .busy(busy), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req       = 3'b000;
        bus_ready = 1'b0;
        data_in   = {4'hC, 4'hB, 4'hA};
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        req       = 3'b111;
        bus_ready = 1'b1;
        data_in   = {4'hC, 4'hB, 4'hA};
        reset_n   = 1'b0;
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
        checks++; if (bus_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_hold_grant: got %b want 000", grant); end
        reset_n = 1'b1;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b want 001", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy); end
        $display("test_reset: grant after release = %b", grant);
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g [10];
        logic [3:0] exp_d [10];
        exp_g = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        exp_d = '{4'hA, 4'hA, 4'h0, 4'hB, 4'hB, 4'h0, 4'hC, 4'hC, 4'h0, 4'hA};
        apply_reset();
        req       = 3'b111;
        bus_ready = 1'b1;
        data_in   = {4'hC, 4'hB, 4'hA};
        for (int c = 0; c < 10; c++) begin
            tick();
            $display("rotation cycle %0d: grant=%b data=%h valid=%b", c, grant, bus_data, bus_valid);
            checks++; if (grant !== exp_g[c]) begin errors++; $display("FAIL rot_grant[%0d]: got %b want %b", c, grant, exp_g[c]); end
            checks++; if (bus_data !== exp_d[c]) begin errors++; $display("FAIL rot_data[%0d]: got %h want %h", c, bus_data, exp_d[c]); end
            checks++; if (bus_valid !== (exp_g[c] != 3'b000)) begin errors++; $display("FAIL rot_valid[%0d]: got %b want %b", c, bus_valid, exp_g[c] != 3'b000); end
        end
    endtask

    task automatic test_withdrawal();
        apply_reset();
        req       = 3'b010;
        bus_ready = 1'b0;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wd_grant: got %b want 010", grant); end
        checks++; if (bus_data !== 4'hB) begin errors++; $display("FAIL wd_data: got %h want B", bus_data); end
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wd_stall_grant: got %b want 010", grant); end
        bus_ready = 1'b1;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wd_after_beat: got %b want 010", grant); end
        req = 3'b000;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL wd_valid_drop: got %b want 0", bus_valid); end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL wd_release: got %b want 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b want 0", busy); end
        req = 3'b111;
        tick();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL wd_next_grant: got %b want 100", grant); end
        $display("test_withdrawal: next grant = %b", grant);
    endtask

    task automatic test_stall();
        apply_reset();
        req       = 3'b001;
        bus_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL stall_grant[%0d]: got %b want 001", i, grant); end
            checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus_valid); end
            checks++; if (bus_data !== 4'hA) begin errors++; $display("FAIL stall_data[%0d]: got %h want A", i, bus_data); end
            tick();
        end
        bus_ready = 1'b1;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL stall_second_beat: got %b want 001", grant); end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL stall_burst_end: got %b want 000", grant); end
        $display("test_stall: burst complete, grant = %b", grant);
    endtask

    task automatic test_midburst_reset();
        apply_reset();
        req       = 3'b111;
        bus_ready = 1'b1;
        tick();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL mb_valid_before: got %b want 1", bus_valid); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mb_grant: got %b want 000", grant); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL mb_valid: got %b want 0", bus_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mb_busy: got %b want 0", busy); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mb_restart: got %b want 001", grant); end
        $display("test_midburst_reset: restart grant = %b", grant);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        req       = 3'b001;
        bus_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL to_hold[%0d]: got %b want 001", i, grant); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early[%0d]: got %b want 0", i, err); end
        end
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL to_release: got %b want 000", grant); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
        req = 3'b011;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL to_next_grant: got %b want 010", grant); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", err); end
        apply_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", err); end
        $display("test_timeout: err cleared by reset");
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        req       = 3'b000;
        bus_ready = 1'b0;
        data_in   = {4'hC, 4'hB, 4'hA};
        test_reset();
        test_rotation();
        test_withdrawal();
        test_stall();
        test_midburst_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
